// File: rtl/status_unit.sv
// ALU result and {N,Z,C,V} flag generation for the EXE stage, with a registered
// status register and a counter of committed flag updates.
module status_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       exe_cmd,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             valid,
   input  logic             s_bit,
   input  logic             freeze,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags_next,
   output logic [3:0]       status,
   output logic [7:0]       upd_cnt
);

   localparam logic [3:0] CmdMov = 4'b0001;
   localparam logic [3:0] CmdMvn = 4'b1001;
   localparam logic [3:0] CmdAdd = 4'b0010;
   localparam logic [3:0] CmdAdc = 4'b0011;
   localparam logic [3:0] CmdSub = 4'b0100;
   localparam logic [3:0] CmdSbc = 4'b0101;
   localparam logic [3:0] CmdAnd = 4'b0110;
   localparam logic [3:0] CmdOrr = 4'b0111;
   localparam logic [3:0] CmdEor = 4'b1000;

   logic [3:0]       status_q, status_d;
   logic [7:0]       upd_cnt_q, upd_cnt_d;
   logic [WIDTH:0]   wide, cin_ext;
   logic [WIDTH-1:0] res;
   logic             nop, c_out, v_out, commit;

   always_comb begin
      cin_ext = '0;
      wide    = '0;
      res     = '0;
      nop     = 1'b0;
      c_out   = status_q[1];
      v_out   = status_q[0];
      case (exe_cmd)
         CmdMov: res = op_b;
         CmdMvn: res = ~op_b;
         CmdAdd, CmdAdc: begin
            // Carry-in comes from the registered C, never from flags_next.
            cin_ext[0] = (exe_cmd == CmdAdc) & status_q[1];
            wide       = {1'b0, op_a} + {1'b0, op_b} + cin_ext;
            res        = wide[WIDTH-1:0];
            c_out      = wide[WIDTH];
            v_out      = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
         end
         CmdSub, CmdSbc: begin
            // Bit WIDTH of the extended difference is the borrow; C is its inverse.
            cin_ext[0] = (exe_cmd == CmdSbc) & ~status_q[1];
            wide       = {1'b0, op_a} - {1'b0, op_b} - cin_ext;
            res        = wide[WIDTH-1:0];
            c_out      = ~wide[WIDTH];
            v_out      = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
         end
         CmdAnd:  res = op_a & op_b;
         CmdOrr:  res = op_a | op_b;
         CmdEor:  res = op_a ^ op_b;
         default: nop = 1'b1;
      endcase
      flags_next = nop ? status_q : {res[WIDTH-1], ~|res, c_out, v_out};
      result     = res;
   end

   always_comb begin
      commit    = valid & s_bit & ~freeze & ~flush & ~nop;
      status_d  = commit ? flags_next : status_q;
      upd_cnt_d = commit ? upd_cnt_q + 8'd1 : upd_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q  <= 4'b0000;
         upd_cnt_q <= 8'd0;
      end else begin
         status_q  <= status_d;
         upd_cnt_q <= upd_cnt_d;
      end
   end

   assign status  = status_q;
   assign upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_status_unit.sv
// Bench for status_unit: a reference model pushes expected results into a
// scoreboard at drive time; each test pops and compares after the clock edge.
module tb_status_unit;

   logic        clk, rst, valid, s_bit, freeze, flush;
   logic [3:0]  exe_cmd, flags_next, status;
   logic [31:0] op_a, op_b, result;
   logic [7:0]  upd_cnt;

   status_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
      .valid(valid), .s_bit(s_bit), .freeze(freeze), .flush(flush),
      .result(result), .flags_next(flags_next), .status(status), .upd_cnt(upd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      logic [3:0]  pre;
      logic [3:0]  st;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          nchk = 0;
   int          nerr = 0;
   logic [3:0]  m_st = 4'b0000;
   logic [7:0]  m_cnt = 8'd0;
   logic [31:0] obs_res;
   logic [3:0]  obs_fl, obs_pre;

   // Independent formulation: 64-bit unsigned compare for C, signed range for V.
   function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] st, output logic [31:0] r,
                                 output logic [3:0] f, output logic nop);
      logic [63:0] u;
      longint      sr;
      logic        c, v, cin;
      c = st[1]; v = st[0]; nop = 1'b0; r = '0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd2, 4'd3: begin
            cin = (cmd == 4'd3) ? st[1] : 1'b0;
            u   = 64'(a) + 64'(b) + 64'(cin);
            r   = u[31:0];
            c   = u > 64'h0000_0000_FFFF_FFFF;
            sr  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
            v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            cin = (cmd == 4'd5) ? ~st[1] : 1'b0;
            r   = a - b - 32'(cin);
            c   = 64'(a) >= 64'(b) + 64'(cin);
            sr  = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
            v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         default: nop = 1'b1;
      endcase
      f = nop ? st : {r[31], r == 32'd0, c, v};
   endfunction

   task automatic step(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic s, input logic fz, input logic fl,
                       input logic r);
      exp_t x;
      logic nop;
      @(negedge clk);
      exe_cmd = cmd; op_a = a; op_b = b; valid = v; s_bit = s;
      freeze = fz; flush = fl; rst = r;
      #1;
      obs_res = result; obs_fl = flags_next; obs_pre = status;
      model(cmd, a, b, m_st, x.res, x.fl, nop);
      x.pre = m_st;
      if (r) begin
         m_st = 4'b0000; m_cnt = 8'd0;
      end else if (v && s && !fz && !fl && !nop) begin
         m_st = x.fl; m_cnt = m_cnt + 8'd1;
      end
      x.st = m_st; x.cnt = m_cnt;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      exe_cmd = 4'b0010; op_a = 32'd1; op_b = 32'd1; valid = 1'b1; s_bit = 1'b1;
      freeze = 1'b0; flush = 1'b0; rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      nchk++; if (status !== 4'b0000) begin nerr++; $display("FAIL reset_status: got %b, expected 0000", status); end
      nchk++; if (upd_cnt !== 8'd0) begin nerr++; $display("FAIL reset_cnt: got %0d, expected 0", upd_cnt); end
      m_st = 4'b0000; m_cnt = 8'd0;
      rst = 1'b0;
   endtask

   task automatic test_add_overflow();
      step(4'b0010, 32'h7FFF_FFFF, 32'd1, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || obs_fl !== e.fl) begin nerr++; $display("FAIL add_comb: result=%h flags=%b, expected %h %b", obs_res, obs_fl, e.res, e.fl); end
      nchk++; if (obs_pre !== e.pre) begin nerr++; $display("FAIL add_same_cycle: status=%b, expected %b", obs_pre, e.pre); end
      nchk++; if (status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL add_reg: status=%b cnt=%0d, expected %b %0d", status, upd_cnt, e.st, e.cnt); end
   endtask

   task automatic test_sub_sbc();
      step(4'b0100, 32'd5, 32'd5, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL cmp: result=%h status=%b cnt=%0d, expected %h %b %0d", obs_res, status, upd_cnt, e.res, e.st, e.cnt); end
      step(4'b0101, 32'd0, 32'd0, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL sbc: result=%h status=%b cnt=%0d, expected %h %b %0d", obs_res, status, upd_cnt, e.res, e.st, e.cnt); end
   endtask

   task automatic test_logic_keeps_cv();
      step(4'b0010, 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL set_cv: status=%b cnt=%0d, expected %b %0d", status, upd_cnt, e.st, e.cnt); end
      step(4'b0110, 32'd0, 32'h0000_00FF, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL and_keep: result=%h status=%b cnt=%0d, expected %h %b %0d", obs_res, status, upd_cnt, e.res, e.st, e.cnt); end
   endtask

   task automatic test_adc_no_s();
      step(4'b0011, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || obs_fl !== e.fl) begin nerr++; $display("FAIL adc_comb: result=%h flags=%b, expected %h %b", obs_res, obs_fl, e.res, e.fl); end
      nchk++; if (status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL adc_no_s: status=%b cnt=%0d, expected %b %0d", status, upd_cnt, e.st, e.cnt); end
   endtask

   task automatic test_freeze_flush();
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 32'h7FFF_FFFF, 32'd1, 1, 1, i != 1, i != 0, 0);
         e = sb.pop_front();
         nchk++; if (obs_fl !== e.fl || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL stall_%0d: flags=%b status=%b cnt=%0d, expected %b %b %0d", i, obs_fl, status, upd_cnt, e.fl, e.st, e.cnt); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cnt0;
      cnt0 = m_cnt;
      for (int i = 0; i < 256; i++) begin
         step(4'($urandom_range(1, 9)), $urandom, (i % 4 == 0) ? 32'h8000_0000 : $urandom,
              1, 1, 0, 0, 0);
         e = sb.pop_front();
         nchk++; if (obs_res !== e.res || obs_fl !== e.fl || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL b2b_%0d: result=%h flags=%b status=%b cnt=%0d, expected %h %b %b %0d", i, obs_res, obs_fl, status, upd_cnt, e.res, e.fl, e.st, e.cnt); end
      end
      nchk++; if (upd_cnt !== cnt0) begin nerr++; $display("FAIL cnt_wrap: got %0d, expected %0d", upd_cnt, cnt0); end
   endtask

   task automatic test_reset_mid();
      step(4'b0100, 32'd0, 32'd1, 1, 1, 0, 0, 1);
      e = sb.pop_front();
      nchk++; if (status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL rst_commit: status=%b cnt=%0d, expected %b %0d", status, upd_cnt, e.st, e.cnt); end
      step(4'b0011, 32'd1, 32'd1, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || status !== e.st || upd_cnt !== e.cnt) begin nerr++; $display("FAIL post_rst: result=%h status=%b cnt=%0d, expected %h %b %0d", obs_res, status, upd_cnt, e.res, e.st, e.cnt); end
      step(4'b0000, 32'd3, 32'd4, 1, 1, 0, 0, 0);
      e = sb.pop_front();
      nchk++; if (obs_res !== e.res || obs_fl !== e.fl || upd_cnt !== e.cnt) begin nerr++; $display("FAIL nop: result=%h flags=%b cnt=%0d, expected %h %b %0d", obs_res, obs_fl, upd_cnt, e.res, e.fl, e.cnt); end
   endtask

   initial begin
      rst = 1'b1; exe_cmd = 4'd0; op_a = '0; op_b = '0;
      valid = 1'b0; s_bit = 1'b0; freeze = 1'b0; flush = 1'b0;
      test_reset();
      test_add_overflow();
      test_sub_sbc();
      test_logic_keeps_cv();
      test_adc_no_s();
      test_freeze_flush();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
